// File: rtl/umem_pkg.sv
// Shared defaults and helpers for the user data memory arbiter.
package umem_pkg;

    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 8;

    // Index width for a value range of n entries; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/umem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick
    import umem_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    logic [IW-1:0] idx;

    // Wrap by explicit compare so non-power-of-two NREQ never visits a phantom slot.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = start;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/umem_arbiter.sv
// Round-robin arbiter for the single-port user data memory, with bounded burst lock
// and one-cycle read return to the issuing requester.
module umem_arbiter
    import umem_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(MAX_LOCK + 1);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic            locked;
    logic [CW-1:0]   lock_cnt;
    logic [NREQ-1:0] rd_pend;
    logic [DW-1:0]   rdata_q;

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   start;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_valid;
    logic [IW-1:0]   gnt_idx;
    logic            issue;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    // While locked, only the owner may be picked; everyone else stalls.
    always_comb begin
        elig  = req;
        start = rr_ptr;
        if (locked) begin
            elig  = req & (NREQ'(1) << owner);
            start = owner;
        end
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (elig),
        .start (start),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick_gnt[i]) gnt_idx = IW'(i);
    end

    // Reset gates the issue path so outputs fall to zero before the next edge.
    assign issue     = pick_valid && !reset;
    assign gnt       = issue ? pick_gnt : '0;
    assign mem_en    = issue;
    assign mem_we    = issue && req_we[gnt_idx];
    assign mem_addr  = issue ? req_addr[int'(gnt_idx)*AW +: AW] : '0;
    assign mem_wdata = issue ? req_wdata[int'(gnt_idx)*DW +: DW] : '0;

    assign rvalid = rd_pend;
    assign rdata  = (|rd_pend) ? mem_rdata : rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            owner    <= '0;
            locked   <= 1'b0;
            lock_cnt <= '0;
            rd_pend  <= '0;
            rdata_q  <= '0;
        end else begin
            rd_pend <= pick_gnt & ~req_we;
            if (|rd_pend)
                rdata_q <= mem_rdata;

            // Expiry is checked first so a still-requesting owner re-arbitrates fairly.
            if (locked) begin
                if (lock_cnt == CW'(MAX_LOCK - 1) || (pick_valid && !req_lock[owner])) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                    rr_ptr   <= next_idx(owner);
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end else if (pick_valid) begin
                rr_ptr <= next_idx(gnt_idx);
                if (req_lock[gnt_idx] && MAX_LOCK > 1) begin
                    locked   <= 1'b1;
                    owner    <= gnt_idx;
                    lock_cnt <= CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_umem_arbiter.sv
// Directed self-checking bench for umem_arbiter with a behavioural synchronous memory.
module tb_umem_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [3:0]  req_lock;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [256];

    int checks;
    int errors;

    umem_arbiter #(.NREQ(4), .AW(8), .DW(8), .MAX_LOCK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic setSlot(input int i, input logic [7:0] a, input logic [7:0] d);
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] we, input logic [3:0] lk);
        @(negedge clk);
        req      = r;
        req_we   = we;
        req_lock = lk;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req       = 4'b1111;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;

        #3;
        checkOutput("reset_gnt", 32'(gnt), 32'h0);
        checkOutput("reset_mem_en", 32'(mem_en), 32'h0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
        checkOutput("reset_rdata", 32'(rdata), 32'h0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'h0);

        @(negedge clk);
        req   = '0;
        reset = 1'b0;

        $display("[TB] single read by requester 0");
        setSlot(0, 8'h10, 8'h00);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("rd_gnt", 32'(gnt), 32'h1);
        checkOutput("rd_mem_en", 32'(mem_en), 32'h1);
        checkOutput("rd_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'h10);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("rd_rvalid", 32'(rvalid), 32'h1);
        checkOutput("rd_rdata", 32'(rdata), 32'hA5);
        checkOutput("idle_gnt", 32'(gnt), 32'h0);
        checkOutput("idle_mem_en", 32'(mem_en), 32'h0);
        checkOutput("idle_mem_addr", 32'(mem_addr), 32'h0);

        $display("[TB] write then read-back by requester 1");
        setSlot(1, 8'h7F, 8'h3C);
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        checkOutput("wr_gnt", 32'(gnt), 32'h2);
        checkOutput("wr_mem_we", 32'(mem_we), 32'h1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'h7F);
        checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("rb_gnt", 32'(gnt), 32'h2);
        checkOutput("rb_mem_we", 32'(mem_we), 32'h0);
        checkOutput("wr_no_rvalid", 32'(rvalid), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("rb_rvalid", 32'(rvalid), 32'h2);
        checkOutput("rb_rdata", 32'(rdata), 32'h3C);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("hold_rvalid", 32'(rvalid), 32'h0);
        checkOutput("hold_rdata", 32'(rdata), 32'h3C);

        $display("[TB] async reset after a read grant");
        setSlot(0, 8'h10, 8'h00);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("rst_rd_gnt", 32'(gnt), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_async_mem_en", 32'(mem_en), 32'h0);
        checkOutput("rst_async_rdata", 32'(rdata), 32'h0);
        @(negedge clk);
        checkOutput("rst_no_rvalid", 32'(rvalid), 32'h0);
        checkOutput("rst_rdata_zero", 32'(rdata), 32'h0);
        req   = '0;
        reset = 1'b0;

        $display("[TB] all four requesting continuously");
        setSlot(0, 8'h00, 8'h00);
        setSlot(1, 8'h01, 8'h00);
        setSlot(2, 8'h02, 8'h00);
        setSlot(3, 8'h03, 8'h00);
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        checkOutput("rr_gnt0", 32'(gnt), 32'h1);
        checkOutput("rr_post_rst_rvalid", 32'(rvalid), 32'h0);
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        checkOutput("rr_gnt1", 32'(gnt), 32'h2);
        checkOutput("rr_rvalid0", 32'(rvalid), 32'h1);
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        checkOutput("rr_gnt2", 32'(gnt), 32'h4);
        checkOutput("rr_addr2", 32'(mem_addr), 32'h02);
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        checkOutput("rr_gnt3", 32'(gnt), 32'h8);
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        checkOutput("rr_gnt4", 32'(gnt), 32'h1);
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        checkOutput("rr_gnt5", 32'(gnt), 32'h2);

        $display("[TB] lock burst by requester 2");
        applyStimulus(4'b1111, 4'b0000, 4'b0100);
        checkOutput("lk_gnt_a", 32'(gnt), 32'h4);
        applyStimulus(4'b1111, 4'b0000, 4'b0100);
        checkOutput("lk_gnt_b", 32'(gnt), 32'h4);
        applyStimulus(4'b1111, 4'b0000, 4'b0100);
        checkOutput("lk_gnt_c", 32'(gnt), 32'h4);
        applyStimulus(4'b1111, 4'b0000, 4'b0100);
        checkOutput("lk_gnt_d", 32'(gnt), 32'h4);
        applyStimulus(4'b1111, 4'b0000, 4'b0100);
        checkOutput("lk_expire_gnt3", 32'(gnt), 32'h8);
        applyStimulus(4'b1111, 4'b0000, 4'b0100);
        checkOutput("lk_after_gnt0", 32'(gnt), 32'h1);

        $display("[TB] locked owner idles");
        applyStimulus(4'b0010, 4'b0000, 4'b0010);
        checkOutput("idl_entry_gnt1", 32'(gnt), 32'h2);
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
        checkOutput("idl_stall_a", 32'(gnt), 32'h0);
        checkOutput("idl_stall_a_en", 32'(mem_en), 32'h0);
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
        checkOutput("idl_stall_b", 32'(gnt), 32'h0);
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
        checkOutput("idl_stall_c", 32'(gnt), 32'h0);
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
        checkOutput("idl_release_gnt3", 32'(gnt), 32'h8);

        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
